// File: rtl/toggle_pulse_meter.sv
// Measures delay from trigger to data leaving its idle band, and how long it stays out, in ce_i samples.
// Optional: define PULSE_METER_DEGLITCH_EN to require two consecutive inactive samples to end a pulse.
module toggle_pulse_meter #(
    parameter int unsigned COUNTER_WIDTH = 18,
    parameter int unsigned DATA_WIDTH    = 14
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         ce_i,
    input  logic                         trig_i,
    input  logic signed [DATA_WIDTH-1:0] data_i,
    input  logic signed [DATA_WIDTH-1:0] idle_data_i,
    input  logic        [DATA_WIDTH-1:0] tol_i,
    output logic [COUNTER_WIDTH-1:0]     delay_cycles_o,
    output logic [COUNTER_WIDTH-1:0]     toggle_cycles_o,
    output logic                         overflow_o,
    output logic                         valid_o,
    output logic                         busy_o
);

    typedef enum logic [1:0] {StIdle, StWait, StMeasure} state_e;

    localparam logic [COUNTER_WIDTH-1:0] CntMax = '1;
    localparam logic [COUNTER_WIDTH-1:0] CntOne = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

    state_e                     state_q, state_d;
    logic [COUNTER_WIDTH-1:0]   dcnt_q, dcnt_d;
    logic [COUNTER_WIDTH-1:0]   tcnt_q, tcnt_d;
    logic [COUNTER_WIDTH-1:0]   delay_q, toggle_q;
    logic                       ovf_q, valid_q;

    logic                       finish;
    logic [COUNTER_WIDTH-1:0]   res_toggle;
    logic                       res_ovf;

`ifdef PULSE_METER_DEGLITCH_EN
    logic                       glitch_q, glitch_d;
`endif

    // One extra bit keeps the signed difference exact for any pair of samples.
    logic signed [DATA_WIDTH:0] diff;
    logic        [DATA_WIDTH:0] diff_mag;
    logic                       active;

    assign diff = $signed({data_i[DATA_WIDTH-1], data_i})
                - $signed({idle_data_i[DATA_WIDTH-1], idle_data_i});

    always_comb begin
        diff_mag = $unsigned(diff);
        if (diff[DATA_WIDTH]) begin
            diff_mag = $unsigned(-diff);
        end
    end

    assign active = (diff_mag > {1'b0, tol_i});

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            dcnt_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            tcnt_q  <= tcnt_d;
        end
    end

`ifdef PULSE_METER_DEGLITCH_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            glitch_q <= 1'b0;
        end else begin
            glitch_q <= glitch_d;
        end
    end
`endif

    // Next-state and counter logic
    always_comb begin
        state_d    = state_q;
        dcnt_d     = dcnt_q;
        tcnt_d     = tcnt_q;
        finish     = 1'b0;
        res_toggle = tcnt_q;
        res_ovf    = 1'b0;
`ifdef PULSE_METER_DEGLITCH_EN
        glitch_d   = glitch_q;
`endif
        if (ce_i) begin
            case (state_q)
                StIdle: begin
                    // The trigger sample itself is never evaluated as data.
                    if (trig_i) begin
                        state_d = StWait;
                        dcnt_d  = '0;
                        tcnt_d  = '0;
                    end
                end
                StWait: begin
                    if (active) begin
                        state_d = StMeasure;
                        tcnt_d  = CntOne;
`ifdef PULSE_METER_DEGLITCH_EN
                        glitch_d = 1'b0;
`endif
                    end else if (dcnt_q == CntMax) begin
                        finish     = 1'b1;
                        res_toggle = '0;
                        res_ovf    = 1'b1;
                    end else begin
                        dcnt_d = dcnt_q + CntOne;
                    end
                end
                StMeasure: begin
                    if (active) begin
`ifdef PULSE_METER_DEGLITCH_EN
                        glitch_d = 1'b0;
`endif
                        if (tcnt_q == CntMax) begin
                            finish  = 1'b1;
                            res_ovf = 1'b1;
                        end else begin
                            tcnt_d = tcnt_q + CntOne;
                        end
`ifdef PULSE_METER_DEGLITCH_EN
                    end else if (!glitch_q) begin
                        // First inactive sample is provisionally counted as active.
                        if (tcnt_q == CntMax) begin
                            finish  = 1'b1;
                            res_ovf = 1'b1;
                        end else begin
                            tcnt_d   = tcnt_q + CntOne;
                            glitch_d = 1'b1;
                        end
                    end else begin
                        // Second inactive in a row: withdraw the provisional count.
                        finish     = 1'b1;
                        res_toggle = tcnt_q - CntOne;
                        glitch_d   = 1'b0;
                    end
`else
                    end else begin
                        finish = 1'b1;
                    end
`endif
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
            if (finish) begin
                state_d = StIdle;
            end
        end
    end

    // Result registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            delay_q  <= '0;
            toggle_q <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= finish;
            if (finish) begin
                delay_q  <= dcnt_q;
                toggle_q <= res_toggle;
                ovf_q    <= res_ovf;
            end
        end
    end

    // Outputs
    always_comb begin
        busy_o          = (state_q != StIdle);
        delay_cycles_o  = delay_q;
        toggle_cycles_o = toggle_q;
        overflow_o      = ovf_q;
        valid_o         = valid_q;
    end

endmodule

// File: tb/tb_toggle_pulse_meter.sv
// Directed, table-driven bench for toggle_pulse_meter; a 4-bit-counter instance covers saturation.
module tb_toggle_pulse_meter;

    localparam int CW = 18;
    localparam int DW = 14;

`ifdef PULSE_METER_DEGLITCH_EN
    localparam int TermLat  = 2;
    localparam int GlitchT  = 6;
`else
    localparam int TermLat  = 1;
    localparam int GlitchT  = 3;
`endif

    logic                 clk_i = 1'b0;
    logic                 rst_ni = 1'b0;
    logic                 ce_i = 1'b0;
    logic                 trig_i = 1'b0;
    logic                 trig4 = 1'b0;
    logic signed [DW-1:0] data_i = '0;
    logic signed [DW-1:0] idle_data_i = '0;
    logic        [DW-1:0] tol_i = '0;

    logic [CW-1:0] delay_cycles_o, toggle_cycles_o;
    logic          overflow_o, valid_o, busy_o;
    logic [3:0]    delay4, toggle4;
    logic          ovf4, valid4, busy4;

    toggle_pulse_meter #(.COUNTER_WIDTH(CW), .DATA_WIDTH(DW)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .ce_i(ce_i), .trig_i(trig_i),
        .data_i(data_i), .idle_data_i(idle_data_i), .tol_i(tol_i),
        .delay_cycles_o(delay_cycles_o), .toggle_cycles_o(toggle_cycles_o),
        .overflow_o(overflow_o), .valid_o(valid_o), .busy_o(busy_o)
    );

    toggle_pulse_meter #(.COUNTER_WIDTH(4), .DATA_WIDTH(DW)) u_dut4 (
        .clk_i(clk_i), .rst_ni(rst_ni), .ce_i(ce_i), .trig_i(trig4),
        .data_i(data_i), .idle_data_i(idle_data_i), .tol_i(tol_i),
        .delay_cycles_o(delay4), .toggle_cycles_o(toggle4),
        .overflow_o(ovf4), .valid_o(valid4), .busy_o(busy4)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail = 0;
    int nvalid = 0;
    int nvalid4 = 0;
    logic [CW-1:0] cap_d, cap_t;
    logic          cap_o;
    logic [3:0]    cap4_d, cap4_t;
    logic          cap4_o;

    typedef struct {
        logic signed [DW-1:0] idle;
        logic        [DW-1:0] tol;
        logic signed [DW-1:0] inact;
        logic signed [DW-1:0] act;
        int n_in;
        int n_act;
        int gap;
        int exp_d;
        int exp_t;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input logic ce, input logic trig, input logic t4,
                        input logic signed [DW-1:0] d);
        @(negedge clk_i);
        ce_i   = ce;
        trig_i = trig;
        trig4  = t4;
        data_i = d;
        @(posedge clk_i);
        #1;
        if (valid_o) begin
            nvalid++;
            cap_d = delay_cycles_o;
            cap_t = toggle_cycles_o;
            cap_o = overflow_o;
        end
        if (valid4) begin
            nvalid4++;
            cap4_d = delay4;
            cap4_t = toggle4;
            cap4_o = ovf4;
        end
    endtask

    task automatic samp(input logic trig, input logic signed [DW-1:0] d, input int gap);
        repeat (gap) tick(1'b0, 1'b0, 1'b0, d);
        tick(1'b1, trig, 1'b0, d);
    endtask

    // Samples inactive data until the main DUT strobes valid; bounded.
    task automatic wait_valid(input logic signed [DW-1:0] d, input int gap, output int k);
        k = 0;
        while (nvalid == 0 && k < 4) begin
            samp(1'b0, d, gap);
            k++;
        end
    endtask

    initial begin
        int k;
        int n;
        vecs[0] = '{14'sd0,    14'd10,    14'sd0,    14'sd500,  5, 7, 0, 5, 7};
        vecs[1] = '{14'sd0,    14'd10,    14'sd0,    14'sd1000, 4, 4, 2, 4, 4};
        vecs[2] = '{14'sd0,    14'd10,    14'sd0,    14'sd1000, 1, 1, 2, 1, 1};
        vecs[3] = '{14'sd0,    14'd10,    -14'sd10,  -14'sd11,  2, 3, 0, 2, 3};
        vecs[4] = '{14'sd8191, 14'd10,    14'sd8191, 14'h2000,  0, 2, 0, 0, 2};
        vecs[5] = '{14'sd0,    14'd10,    14'sd10,   14'sd11,   3, 1, 0, 3, 1};
        vecs[6] = '{-14'sd100, 14'd0,     -14'sd100, -14'sd99,  1, 2, 1, 1, 2};
        vecs[7] = '{14'sd8191, 14'd16382, 14'sd8191, 14'h2000,  2, 3, 0, 2, 3};

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        check("rst delay", delay_cycles_o, 0);
        check("rst toggle", toggle_cycles_o, 0);
        check("rst ovf", overflow_o, 0);
        check("rst valid", valid_o, 0);
        check("rst busy", busy_o, 0);
        check("rst busy4", busy4, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Table-driven measurements; each trigger lands on the first ce after the previous result.
        for (int i = 0; i < 8; i++) begin
            idle_data_i = vecs[i].idle;
            tol_i       = vecs[i].tol;
            nvalid      = 0;
            samp(1'b1, vecs[i].inact, vecs[i].gap);
            check($sformatf("v%0d busy after trig", i), busy_o, 1);
            repeat (vecs[i].n_in) samp(1'b0, vecs[i].inact, vecs[i].gap);
            repeat (vecs[i].n_act) samp(1'b0, vecs[i].act, vecs[i].gap);
            check($sformatf("v%0d no early valid", i), nvalid, 0);
            wait_valid(vecs[i].inact, vecs[i].gap, k);
            check($sformatf("v%0d latency", i), k, TermLat);
            tick(1'b0, 1'b0, 1'b0, vecs[i].inact);
            check($sformatf("v%0d valid pulses", i), nvalid, 1);
            check($sformatf("v%0d delay", i), cap_d, vecs[i].exp_d);
            check($sformatf("v%0d toggle", i), cap_t, vecs[i].exp_t);
            check($sformatf("v%0d ovf", i), cap_o, 0);
            check($sformatf("v%0d busy end", i), busy_o, 0);
        end

        // Glitch handling: active 3, inactive 1, active 2, inactive 2
        idle_data_i = 14'sd0;
        tol_i       = 14'd10;
        nvalid      = 0;
        samp(1'b1, 14'sd0, 0);
        repeat (3) samp(1'b0, 14'sd500, 0);
        samp(1'b0, 14'sd0, 0);
        repeat (2) samp(1'b0, 14'sd500, 0);
        repeat (2) samp(1'b0, 14'sd0, 0);
        tick(1'b0, 1'b0, 1'b0, 14'sd0);
        check("glitch valid pulses", nvalid, 1);
        check("glitch delay", cap_d, 0);
        check("glitch toggle", cap_t, GlitchT);
        check("glitch busy end", busy_o, 0);

        // Retrigger during MEASURE is ignored
        nvalid = 0;
        samp(1'b1, 14'sd0, 0);
        repeat (2) samp(1'b0, 14'sd0, 0);
        repeat (2) samp(1'b0, 14'sd500, 0);
        samp(1'b1, 14'sd500, 0);
        check("retrig busy", busy_o, 1);
        samp(1'b0, 14'sd500, 0);
        wait_valid(14'sd0, 0, k);
        check("retrig latency", k, TermLat);
        check("retrig delay", cap_d, 2);
        check("retrig toggle", cap_t, 4);

        // ce_i low holds everything
        nvalid = 0;
        samp(1'b1, 14'sd0, 0);
        repeat (5) tick(1'b0, 1'b1, 1'b0, 14'sd500);
        check("ce hold busy", busy_o, 1);
        samp(1'b0, 14'sd0, 0);
        samp(1'b0, 14'sd500, 0);
        wait_valid(14'sd0, 0, k);
        check("ce hold delay", cap_d, 1);
        check("ce hold toggle", cap_t, 1);

        // Reset asserted in WAIT aborts the measurement
        nvalid = 0;
        samp(1'b1, 14'sd0, 0);
        repeat (2) samp(1'b0, 14'sd0, 0);
        check("pre-reset busy", busy_o, 1);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("async rst delay", delay_cycles_o, 0);
        check("async rst toggle", toggle_cycles_o, 0);
        check("async rst ovf", overflow_o, 0);
        check("async rst busy", busy_o, 0);
        repeat (2) tick(1'b1, 1'b0, 1'b0, 14'sd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) samp(1'b0, 14'sd500, 0);
        repeat (3) samp(1'b0, 14'sd0, 0);
        check("post-reset no valid", nvalid, 0);
        check("post-reset busy", busy_o, 0);

        // Delay saturation on the 4-bit instance: finishes on the inactive sample seen at dcnt==15
        nvalid4 = 0;
        tick(1'b1, 1'b0, 1'b1, 14'sd0);
        n = 0;
        while (nvalid4 == 0 && n < 40) begin
            tick(1'b1, 1'b0, 1'b0, 14'sd0);
            n++;
        end
        tick(1'b0, 1'b0, 1'b0, 14'sd0);
        check("sat4 samples", n, 16);
        check("sat4 valid pulses", nvalid4, 1);
        check("sat4 delay", cap4_d, 15);
        check("sat4 toggle", cap4_t, 0);
        check("sat4 ovf", cap4_o, 1);
        check("sat4 busy", busy4, 0);

        // Toggle saturation on the 4-bit instance
        nvalid4 = 0;
        tick(1'b1, 1'b0, 1'b1, 14'sd0);
        n = 0;
        while (nvalid4 == 0 && n < 40) begin
            tick(1'b1, 1'b0, 1'b0, 14'sd500);
            n++;
        end
        check("tsat4 samples", n, 16);
        check("tsat4 delay", cap4_d, 0);
        check("tsat4 toggle", cap4_t, 15);
        check("tsat4 ovf", cap4_o, 1);
        check("main untouched", nvalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
